// File: rtl/light_data_filter_if.sv
// Bus bundle for the light data filter: raw sample input side, control
// strobes and the processed result side.
//
// Handshake: data_in is consumed on every rising clk_in edge at which
// data_in_valid is high (and flush is low). There is no ready signal; the
// filter takes one sample per cycle indefinitely. data_out_valid is a
// one-cycle strobe and the consumer must take the result on that edge.
interface light_data_filter_if #(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 8
);
    logic [DIN_W-1:0]  data_in;
    logic              data_in_valid;
    logic [3:0]        shift_sel;
    logic              flush;
    logic [DOUT_W-1:0] data_out;
    logic              data_out_valid;
    logic              sat_flag;
    logic              alarm_out;

    // Sample producer / result consumer
    modport master (
        output data_in, data_in_valid, shift_sel, flush,
        input  data_out, data_out_valid, sat_flag, alarm_out
    );

    // The filter itself
    modport slave (
        input  data_in, data_in_valid, shift_sel, flush,
        output data_out, data_out_valid, sat_flag, alarm_out
    );
endinterface

// File: rtl/light_data_filter.sv
// Light sensor filter: moving average over a 2^AVG_LOG2 sample window,
// programmable right shift, saturation to DOUT_W bits and a hysteretic
// threshold alarm. Result appears two edges after the sample is taken.
module light_data_filter #(
    parameter int DIN_W    = 16,
    parameter int DOUT_W   = 8,
    parameter int AVG_LOG2 = 2,
    parameter int TH_HI    = 200,
    parameter int TH_LO    = 100
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    light_data_filter_if.slave    bus,
    output logic                  fsm_state   // 0 = FILL, 1 = RUN
);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W  = DIN_W + AVG_LOG2;
    localparam logic SINGLE = (AVG_LOG2 == 0);
    localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'({DOUT_W{1'b1}});

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [DIN_W-1:0]   win [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [SUM_W-1:0]   sum;
    logic               s1_valid;
    logic [3:0]         s1_shift;
    logic               s2_valid;
    logic [DOUT_W-1:0]  s2_data;
    logic               s2_sat;
    logic               accept;
    logic               last_slot;
    logic               produce;
    logic [SUM_W-1:0]   avg;
    logic [SUM_W-1:0]   scaled;
    logic               sat_c;
    logic [DOUT_W-1:0]  data_c;

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= FILL;
        else           state <= state_nxt;
    end

    // FSM next state: flush always returns to FILL, the filling sample moves to RUN
    always_comb begin
        state_nxt = state;
        if (bus.flush)
            state_nxt = FILL;
        else if (state == FILL && accept && last_slot)
            state_nxt = RUN;
    end

    // FSM outputs: sample acceptance and whether the sample yields a result
    always_comb begin
        accept    = bus.data_in_valid & ~bus.flush;
        last_slot = (wr_ptr == PTR_W'(DEPTH - 1));
        produce   = accept & ((state == RUN) | SINGLE);
        fsm_state = (state == RUN);
    end

    // Stage 1: window write, running sum update, capture of shift amount
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wr_ptr   <= '0;
            sum      <= '0;
            s1_valid <= 1'b0;
            s1_shift <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            wr_ptr   <= '0;
            sum      <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= produce;
            if (accept) begin
                win[wr_ptr] <= bus.data_in;
                sum         <= sum + SUM_W'(bus.data_in) - SUM_W'(win[wr_ptr]);
                wr_ptr      <= last_slot ? '0 : wr_ptr + PTR_W'(1);
                s1_shift    <= bus.shift_sel;
            end
        end
    end

    // Averaging, scaling and saturation from the registered sum
    always_comb begin
        avg    = sum >> AVG_LOG2;
        scaled = avg >> s1_shift;
        sat_c  = (scaled > OUT_MAX);
        data_c = sat_c ? '1 : scaled[DOUT_W-1:0];
    end

    // Stage 2: hold the saturated result one cycle; flush drops it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
        end else if (bus.flush) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= data_c;
                s2_sat  <= sat_c;
            end
        end
    end

    // Output stage: publish result, update hysteretic alarm, hold between results
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.data_out       <= '0;
            bus.data_out_valid <= 1'b0;
            bus.sat_flag       <= 1'b0;
            bus.alarm_out      <= 1'b0;
        end else begin
            bus.data_out_valid <= s2_valid & ~bus.flush;
            if (s2_valid && !bus.flush) begin
                bus.data_out <= s2_data;
                bus.sat_flag <= s2_sat;
                if (s2_data >= DOUT_W'(TH_HI))
                    bus.alarm_out <= 1'b1;
                else if (s2_data <= DOUT_W'(TH_LO))
                    bus.alarm_out <= 1'b0;
            end
        end
    end
endmodule

// File: doc/light_data_filter.md
LIGHT_DATA_FILTER -- requirements
Module: light_data_filter

Interface
REQ-001 SHALL have parameter DIN_W, default 16, raw sensor word width.
REQ-002 SHALL have parameter DOUT_W, default 8, processed output width.
REQ-003 SHALL have parameter AVG_LOG2, default 2, averaging window = 2^AVG_LOG2 samples (range 0..4).
REQ-004 SHALL have parameter TH_HI, default 200, alarm set threshold, compared against data_out.
REQ-005 SHALL have parameter TH_LO, default 100, alarm clear threshold; TH_LO < TH_HI required.
REQ-006 SHALL have port clk_in, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port data_in, input, DIN_W, raw light sample.
REQ-009 SHALL have port data_in_valid, input, 1, one-cycle qualifier for data_in.
REQ-010 SHALL have port shift_sel, input, 4, right-shift amount after averaging (10 reproduces the legacy lux scaling).
REQ-011 SHALL have port flush, input, 1, synchronous clear of the window and pipeline.
REQ-012 SHALL have port data_out, output, DOUT_W, averaged, scaled, saturated result.
REQ-013 SHALL have port data_out_valid, output, 1, one-cycle strobe per new result.
REQ-014 SHALL have port sat_flag, output, 1, set with data_out when saturation occurred.
REQ-015 SHALL have port alarm_out, output, 1, hysteretic threshold alarm.

Function
REQ-016 SHALL keep a circular buffer of 2^AVG_LOG2 samples, a write pointer, and a running sum of width DIN_W+AVG_LOG2.
REQ-017 SHALL, on each accepted sample, replace the oldest entry and update sum = sum + new - oldest in the same cycle (stage 1).
REQ-018 SHALL run a two-state FSM: FILL (fewer than 2^AVG_LOG2 samples since reset/flush) and RUN; FILL->RUN on the sample that fills the window, and RUN persists until flush or reset.
REQ-019 SHALL suppress data_out_valid while in FILL, including for the filling sample itself, which produces no result; the first data_out_valid is caused by the sample after the filling sample, except when AVG_LOG2 = 0, in which case every accepted sample produces a result.
REQ-020 SHALL, in stage 2, compute avg = sum >> AVG_LOG2, then scaled = avg >> shift_sel, with shift_sel captured in stage 1 alongside the sample.
REQ-021 SHALL saturate: if scaled > 2^DOUT_W-1 then data_out = all ones and sat_flag = 1, else data_out = scaled[DOUT_W-1:0] and sat_flag = 0.
REQ-022 SHALL have a latency of 2 clock edges from the clk_in edge at which data_in_valid is sampled high to the edge at which data_out_valid goes high, with data_out, sat_flag and alarm_out updated on that same edge.
REQ-023 SHALL accept back-to-back samples every cycle with no stalls; no back-pressure.
REQ-024 SHALL hold data_out, sat_flag and alarm_out between results.
REQ-025 SHALL set alarm_out when a new data_out >= TH_HI, clear it when a new data_out <= TH_LO, and otherwise hold it.
REQ-026 SHALL, on flush, clear buffer, sum, pointer and pipeline valid and enter FILL; data_out, sat_flag and alarm_out hold their values.
REQ-027 SHALL give flush priority when flush and data_in_valid occur together; the sample is dropped.
REQ-028 SHALL drop any result in flight in stage 2 when flush is asserted.

Reset
REQ-029 SHALL, while rst_n_in = 0, force data_out = 0, data_out_valid = 0, sat_flag = 0, alarm_out = 0, sum = 0, pointer = 0, buffer = 0 and FSM = FILL, independent of clk_in.
REQ-030 SHALL, on reset assertion mid-operation, discard all in-flight samples; after release, behaviour is identical to power-up.

Verification
REQ-031 SHALL be verified as follows: reset asserted mid-stream -> all outputs 0 immediately; after release, no data_out_valid until 1 + 2^AVG_LOG2 samples have been fed.
REQ-032 SHALL be verified as follows: defaults, shift_sel=10, five samples of 0x2800 -> no strobe for samples 1-4; sample 5 gives data_out=10, sat_flag=0 two edges after it is sampled.
REQ-033 SHALL be verified as follows: window of zeros in RUN, shift_sel=4, one sample 0x1000 -> sum=0x1000, avg=0x400, data_out=64.
REQ-034 SHALL be verified as follows: window full of 0xFFFF, shift_sel=0 -> data_out=255, sat_flag=1; then shift_sel=10 -> data_out=63, sat_flag=0.
REQ-035 SHALL be verified as follows: successive results 210, 150, 90 -> alarm_out 1, 1, 0; then 150 -> alarm_out stays 0.
REQ-036 SHALL be verified as follows: flush together with data_in_valid in RUN -> sample dropped, FSM=FILL, data_out held, next strobe only after 1 + 2^AVG_LOG2 new samples.
